// File: rtl/iq_trunc_pack_if.sv
// Valid/ready sample stream carrying one data word plus a packet-end flag.
interface iq_trunc_pack_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/iq_trunc_pack.sv
// IQ requantiser and packer: reduces each IN_W-bit I/Q component to OUT_W
// bits (truncate or round-half-up with saturation) and packs N samples per
// output word, flushing a partial word on tlast.

// Per-component reduction, purely combinational.
module iq_trunc_pack_lane #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 4
) (
  input  logic             round_en,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);
  localparam int D = IN_W - OUT_W;
  localparam logic [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (D - 1);

  logic [IN_W:0]  sum;
  logic [OUT_W:0] r;
  logic           unused_frac;

  // One guard bit above the input so +HALF cannot wrap; only the positive
  // side can actually overflow, but the clamp handles either sign.
  assign sum         = {x[IN_W-1], x} + HALF;
  assign r           = sum[IN_W:D];
  assign unused_frac = ^sum[D-1:0];

  // Select truncation or saturated rounding.
  always_comb begin
    y = x[IN_W-1:D];
    if (round_en) begin
      if (r[OUT_W] != r[OUT_W-1])
        y = r[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      else
        y = r[OUT_W-1:0];
    end
  end
endmodule

module iq_trunc_pack #(
  parameter int WIDTH = 32,
  parameter int IN_W  = 16,
  parameter int OUT_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           round_en,
  iq_trunc_pack_if.slave  i,
  iq_trunc_pack_if.master o
);
  localparam int N  = WIDTH / (2 * OUT_W);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [1:0][OUT_W-1:0]         red;      // [1]=I, [0]=Q
  logic [2*OUT_W-1:0]            smp;
  logic [N-1:0][2*OUT_W-1:0]     acc_q;
  logic [N-1:0][2*OUT_W-1:0]     word_nxt;
  logic [N-1:0][2*OUT_W-1:0]     out_q;
  logic [SW-1:0]                 slot_q;
  logic                          out_vld_q;
  logic                          out_last_q;
  logic                          accept;
  logic                          complete;

  // One reduction lane per component; index 1 is I (upper half of tdata).
  for (genvar c = 0; c < 2; c++) begin : g_lane
    iq_trunc_pack_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
      .round_en (round_en),
      .x        (i.tdata[c*IN_W +: IN_W]),
      .y        (red[c])
    );
  end

  assign smp      = {red[1], red[0]};
  assign i.tready = ~out_vld_q | o.tready;
  assign accept   = i.tvalid & i.tready;
  assign complete = (slot_q == SW'(N - 1)) | i.tlast;

  assign o.tdata  = out_q;
  assign o.tlast  = out_last_q;
  assign o.tvalid = out_vld_q;

  // Accumulator with the incoming sample dropped into the current slot.
  always_comb begin
    word_nxt         = acc_q;
    word_nxt[slot_q] = smp;
  end

  // Slot/accumulator advance and output holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      slot_q     <= '0;
      out_q      <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      if (out_vld_q & o.tready)
        out_vld_q <= 1'b0;
      if (accept) begin
        if (complete) begin
          // Unfilled slots stay zero because the accumulator was cleared.
          out_q      <= word_nxt;
          out_last_q <= i.tlast;
          out_vld_q  <= 1'b1;
          acc_q      <= '0;
          slot_q     <= '0;
        end else begin
          acc_q  <= word_nxt;
          slot_q <= slot_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_iq_trunc_pack.sv
// Directed bench for iq_trunc_pack: default (OUT_W=4) and OUT_W=8 instances.
module tb_iq_trunc_pack;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic round_en = 1'b0;

  int chk_cnt = 0;
  int pass_cnt = 0;

  iq_trunc_pack_if #(.WIDTH(32)) a_i ();
  iq_trunc_pack_if #(.WIDTH(32)) a_o ();
  iq_trunc_pack_if #(.WIDTH(32)) b_i ();
  iq_trunc_pack_if #(.WIDTH(32)) b_o ();

  iq_trunc_pack #(.WIDTH(32), .IN_W(16), .OUT_W(4)) dut_a (
    .clk(clk), .reset(reset), .round_en(round_en), .i(a_i), .o(a_o)
  );
  iq_trunc_pack #(.WIDTH(32), .IN_W(16), .OUT_W(8)) dut_b (
    .clk(clk), .reset(reset), .round_en(round_en), .i(b_i), .o(b_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one beat to dut_a; returns #1 after the accepting edge.
  task automatic beat_a(input logic [15:0] iv, input logic [15:0] qv, input logic last);
    a_i.tdata  = {iv, qv};
    a_i.tlast  = last;
    a_i.tvalid = 1'b1;
    @(posedge clk); #1;
    a_i.tvalid = 1'b0;
    a_i.tlast  = 1'b0;
  endtask

  task automatic beat_b(input logic [15:0] iv, input logic [15:0] qv, input logic last);
    b_i.tdata  = {iv, qv};
    b_i.tlast  = last;
    b_i.tvalid = 1'b1;
    @(posedge clk); #1;
    b_i.tvalid = 1'b0;
    b_i.tlast  = 1'b0;
  endtask

  task automatic four_a();
    beat_a(16'h1234, 16'hABCD, 1'b0);
    beat_a(16'h5678, 16'hEF01, 1'b0);
    beat_a(16'h9ABC, 16'hDEF0, 1'b0);
    beat_a(16'h7FFF, 16'h8000, 1'b0);
  endtask

  logic [31:0] bp_exp [3];
  logic [31:0] held;
  logic        held_vld;
  logic        acc;
  int          idx;
  int          got;

  initial begin
    a_i.tdata = '0; a_i.tlast = 1'b0; a_i.tvalid = 1'b0; a_o.tready = 1'b1;
    b_i.tdata = '0; b_i.tlast = 1'b0; b_i.tvalid = 1'b0; b_o.tready = 1'b1;
    bp_exp[0] = 32'h3C2D1E0F;
    bp_exp[1] = 32'h78695A4B;
    bp_exp[2] = 32'hB4A59687;

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", a_o.tvalid, 1'b0);
    chk("rst_last",  a_o.tlast,  1'b0);
    chk("rst_data",  a_o.tdata,  32'h0);
    chk("rst_ready", a_i.tready, 1'b1);
    chk("rst_b_valid", b_o.tvalid, 1'b0);

    // Truncate, full word
    beat_a(16'h1234, 16'hABCD, 1'b0);
    beat_a(16'h5678, 16'hEF01, 1'b0);
    beat_a(16'h9ABC, 16'hDEF0, 1'b0);
    chk("t1_early_valid", a_o.tvalid, 1'b0);
    beat_a(16'h7FFF, 16'h8000, 1'b0);
    chk("t1_valid", a_o.tvalid, 1'b1);
    chk("t1_data",  a_o.tdata,  32'h789D5E1A);
    chk("t1_last",  a_o.tlast,  1'b0);
    @(posedge clk); #1;
    chk("t1_one_cycle", a_o.tvalid, 1'b0);

    // Round with saturation, tlast on a full word
    round_en = 1'b1;
    beat_a(16'h7FFF, 16'h8000, 1'b0);
    beat_a(16'h0800, 16'hF7FF, 1'b0);
    beat_a(16'h0000, 16'h0000, 1'b0);
    beat_a(16'h07FF, 16'h0000, 1'b1);
    chk("t2_valid", a_o.tvalid, 1'b1);
    chk("t2_data",  a_o.tdata,  32'h00001F78);
    chk("t2_last",  a_o.tlast,  1'b1);
    @(posedge clk); #1;
    round_en = 1'b0;

    // Short packet, then next packet starts at slot 0
    beat_a(16'h1234, 16'hABCD, 1'b0);
    beat_a(16'h5678, 16'hEF01, 1'b1);
    chk("t3_valid", a_o.tvalid, 1'b1);
    chk("t3_data",  a_o.tdata,  32'h00005E1A);
    chk("t3_last",  a_o.tlast,  1'b1);
    four_a();
    chk("t3_next_valid", a_o.tvalid, 1'b1);
    chk("t3_next_data",  a_o.tdata,  32'h789D5E1A);
    chk("t3_next_last",  a_o.tlast,  1'b0);
    @(posedge clk); #1;

    // Backpressure: o_tready low for 10 cycles, 12 samples offered
    idx = 0; got = 0; held_vld = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      a_o.tready = (cyc >= 10);
      if (idx < 12) begin
        a_i.tdata  = {4'(idx), 12'h000, 4'(15 - idx), 12'h000};
        a_i.tvalid = 1'b1;
      end else begin
        a_i.tvalid = 1'b0;
      end
      @(negedge clk);
      if (a_o.tvalid && !a_o.tready) begin
        chk("bp_ready_low", a_i.tready, 1'b0);
        if (held_vld) chk("bp_stable", a_o.tdata, held);
        held     = a_o.tdata;
        held_vld = 1'b1;
      end else begin
        held_vld = 1'b0;
      end
      if (a_o.tvalid && a_o.tready) begin
        chk("bp_word", a_o.tdata, bp_exp[got]);
        chk("bp_last", a_o.tlast, 1'b0);
        got++;
      end
      acc = a_i.tvalid & a_i.tready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    a_i.tvalid = 1'b0;
    a_o.tready = 1'b1;
    chk("bp_words", 32'(got), 32'd3);
    chk("bp_consumed", 32'(idx), 32'd12);
    @(posedge clk); #1;
    chk("bp_no_dup", a_o.tvalid, 1'b0);

    // Reset mid-word discards the partial word
    beat_a(16'h1234, 16'hABCD, 1'b0);
    beat_a(16'h5678, 16'hEF01, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_rst_valid", a_o.tvalid, 1'b0);
    beat_a(16'h1234, 16'hABCD, 1'b0);
    beat_a(16'h5678, 16'hEF01, 1'b0);
    chk("t5_no_stale", a_o.tvalid, 1'b0);
    beat_a(16'h9ABC, 16'hDEF0, 1'b0);
    chk("t5_no_stale3", a_o.tvalid, 1'b0);
    beat_a(16'h7FFF, 16'h8000, 1'b0);
    chk("t5_valid", a_o.tvalid, 1'b1);
    chk("t5_data",  a_o.tdata,  32'h789D5E1A);
    @(posedge clk); #1;

    // OUT_W=8 variant, truncate
    beat_b(16'h1234, 16'hABCD, 1'b0);
    chk("t6_early_valid", b_o.tvalid, 1'b0);
    beat_b(16'h7FFF, 16'h8000, 1'b0);
    chk("t6_valid", b_o.tvalid, 1'b1);
    chk("t6_data",  b_o.tdata,  32'h7F8012AB);
    chk("t6_last",  b_o.tlast,  1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
